vnc_pool_ctrl: RTL and testbench
================================

Name: vnc_pool_ctrl

Overview:
Scheduler and packer that shares one von Neumann debiasing stage between NSRC raw entropy sources.
- Round-robin selects one unmasked source per bit pair.
- Debiases the pair and packs accepted bits into WORD_W-bit words.
- Presents each word on a valid/ready handshake to the downstream consumer (CSR/FIFO).
- Sits between the raw ring-oscillator samplers and the random-word register.

Parameters:
NSRC, 4, number of raw bit sources (2..16)
WORD_W, 32, output word width (8..64)
REP_LIMIT, 31, repetition-count health threshold per source (used only with health feature)
CNT_W, 16, width of saturating discard counter

Ports:
clk  input  1  system clock
rstn  input  1  reset, asynchronous assert, active-low
enable  input  1  run request; 0 = stop after current pair
src_bits  input  NSRC  raw bits, one per source, sampled on clk
src_mask  input  NSRC  1 = source eligible for selection
word_data  output  WORD_W  packed debiased word
word_valid  output  1  word_data holds a complete word
word_ready  input  1  consumer accepts word
busy  output  1  high in FIRST, SECOND or HOLD
discard_cnt  output  CNT_W  saturating count of rejected pairs (00/11)
fail  output  1  health failure latched
fail_src  output  clog2(NSRC)  source index that failed

Behaviour:
- Reset values: word_data=0, word_valid=0, busy=0, discard_cnt=0, fail=0, fail_src=0.
- Internal reset values: state=IDLE, cur=0, bit count=0.
- Reset mid-operation discards everything, including any partial or held word.
- States: IDLE, FIRST, SECOND, HOLD, FAIL (FAIL exists only with the health feature).
- IDLE: if enable=1 and src_mask!=0, load cur with the lowest-index unmasked source and go to FIRST. Otherwise stay; bit count is cleared.
- FIRST: capture b0=src_bits[cur]; go to SECOND.
- SECOND: capture b1=src_bits[cur].
  - b0!=b1: write b0 into word_data[count] and increment count. (1,0) yields 1; (0,1) yields 0.
  - b0==b1: discard the pair; discard_cnt++, saturating at all-ones.
  - Then advance cur to the next unmasked index above cur, wrapping to 0.
  - If count reaches WORD_W, go to HOLD.
  - Otherwise, if enable=0 or src_mask==0, go to IDLE and drop the partial word (count=0).
  - Otherwise go to FIRST.
- Timing: 2 cycles per pair. First bit lands in word_data[0]. Minimum word period is 2*WORD_W cycles plus 1 HOLD cycle.
- HOLD: word_valid=1 and word_data stable until word_valid&&word_ready.
  - On handshake: count=0, word_valid=0 next cycle, next state FIRST if enable && src_mask!=0, else IDLE.
  - enable=0 in HOLD does not withdraw the word.
  - word_ready high while not valid has no effect.
- src_mask changes take effect at the next cur selection. A pair already in progress completes on its source even if that source becomes masked.
- Only cur is sampled; the other sources are ignored in that cycle.

Optional Feature:
Macro VNC_POOL_HEALTH_EN.

Defined:
- Per-source repetition counter (width clog2(REP_LIMIT+1)), updated on every sample taken from that source.
  - Sample equals that source's previous sample: counter increments.
  - Otherwise: counter reloads to 1.
- Counters persist across pairs and words.
- When a counter reaches REP_LIMIT:
  - go to FAIL next cycle; fail=1 and fail_src=that index.
  - word_valid=0 and any partial or held word is dropped.
  - busy=0.
- FAIL exits only via rstn.
- A failure and a word completion in the same cycle: failure wins.

Undefined:
- No counters and no FAIL state; fail and fail_src are tied to 0.

Test Plan:
- WORD_W=8, mask=0001, src0 drives pairs 10,01,10,10,01,01,10,01 -> after 16 cycles word_valid=1, word_data=8'b0100_1101. word_ready held low 5 cycles -> data stable; ready=1 -> valid drops next cycle.
- mask=1011, all sources toggling -> cur visits 0,1,3,0,1,3. Flip mask to 0001 mid-pair on src3 -> that pair completes on src3, next pair uses src0.
- src0 constant 1 for 10 pairs -> discard_cnt=10, no bit accepted; force counter to near max -> saturates at 16'hFFFF.
- enable dropped after 3 accepted bits -> current pair completes, IDLE, busy=0. Re-enable -> the next word starts at word_data[0].
- Health enabled, REP_LIMIT=7, mask=0101, src2 stuck at 0 -> src2 reaches 7 consecutive samples: fail=1, fail_src=2, word_valid=0, stays failed until rstn pulse.
- rstn asserted in HOLD with word_valid=1 -> all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/vnc_pool_ctrl.sv
// Round-robin scheduler sharing one von Neumann debiaser across NSRC raw sources,
// packing accepted bits into WORD_W-bit words. Define VNC_POOL_HEALTH_EN for repetition-count health tests.
module vnc_pool_ctrl #(
  parameter int NSRC      = 4,
  parameter int WORD_W    = 32,
  parameter int REP_LIMIT = 31,
  parameter int CNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    enable,
  input  logic [NSRC-1:0]         src_bits,
  input  logic [NSRC-1:0]         src_mask,
  output logic [WORD_W-1:0]       word_data,
  output logic                    word_valid,
  input  logic                    word_ready,
  output logic                    busy,
  output logic [CNT_W-1:0]        discard_cnt,
  output logic                    fail,
  output logic [$clog2(NSRC)-1:0] fail_src
);

  localparam int IDX_W = $clog2(NSRC);
  localparam int BIT_W = $clog2(WORD_W + 1);
  localparam int POS_W = $clog2(WORD_W);
  localparam int REP_W = $clog2(REP_LIMIT + 1);

  if (NSRC < 2 || NSRC > 16 || WORD_W < 8 || WORD_W > 64 || REP_LIMIT < 1 || REP_W < 1) begin : g_bad_params
    $error("vnc_pool_ctrl: parameter out of range");
  end

`ifdef VNC_POOL_HEALTH_EN
  typedef enum logic [2:0] {S_IDLE, S_FIRST, S_SECOND, S_HOLD, S_FAIL} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_FIRST, S_SECOND, S_HOLD} state_e;
`endif

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   cur_q, cur_d;
  logic [BIT_W-1:0]   cnt_q, cnt_d;
  logic               b0_q, b0_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic [CNT_W-1:0]   disc_q, disc_d;
  logic               cur_bit;
  logic               run_ok;
  logic [POS_W-1:0]   pos;

  // First eligible source scanning upward from 'from' (inclusive or exclusive), wrapping.
  function automatic logic [IDX_W-1:0] pick_src(input logic [NSRC-1:0] mask,
                                                input logic [IDX_W-1:0] from,
                                                input logic             incl);
    logic [IDX_W-1:0] res;
    logic [IDX_W-1:0] idx;
    logic             found;
    res   = '0;
    found = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      idx = IDX_W'((int'(from) + k + (incl ? 0 : 1)) % NSRC);
      if (!found && mask[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign cur_bit = src_bits[cur_q];
  assign run_ok  = enable && (src_mask != '0);
  assign pos     = cnt_q[POS_W-1:0];

`ifdef VNC_POOL_HEALTH_EN
  logic [REP_W-1:0] rep_q [NSRC];
  logic [REP_W-1:0] rep_d [NSRC];
  logic [NSRC-1:0]  last_q, last_d;
  logic [IDX_W-1:0] fail_src_q, fail_src_d;
  logic             rep_hit;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    state_d = state_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    b0_d    = b0_q;
    word_d  = word_q;
    disc_d  = disc_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (run_ok) begin
          cur_d   = pick_src(src_mask, '0, 1'b1);
          state_d = S_FIRST;
        end
      end
      S_FIRST: begin
        b0_d    = cur_bit;
        state_d = S_SECOND;
      end
      S_SECOND: begin
        if (b0_q != cur_bit) begin
          word_d[pos] = b0_q;
          cnt_d       = cnt_q + 1'b1;
        end else if (disc_q != '1) begin
          disc_d = disc_q + 1'b1;
        end
        cur_d = pick_src(src_mask, cur_q, 1'b0);
        if (cnt_d == BIT_W'(WORD_W)) begin
          state_d = S_HOLD;
        end else if (!run_ok) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          state_d = S_FIRST;
        end
      end
      S_HOLD: begin
        if (word_ready) begin
          cnt_d = '0;
          if (run_ok) begin
            // Mask may have changed while the word was held; revalidate cur.
            cur_d   = pick_src(src_mask, cur_q, 1'b1);
            state_d = S_FIRST;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
`ifdef VNC_POOL_HEALTH_EN
      S_FAIL: state_d = S_FAIL;
`endif
      default: state_d = S_IDLE;
    endcase

`ifdef VNC_POOL_HEALTH_EN
    rep_d      = rep_q;
    last_d     = last_q;
    fail_src_d = fail_src_q;
    rep_hit    = 1'b0;
    if (state_q == S_FIRST || state_q == S_SECOND) begin
      last_d[cur_q] = cur_bit;
      if (rep_q[cur_q] != '0 && last_q[cur_q] == cur_bit) begin
        if (rep_q[cur_q] != REP_W'(REP_LIMIT)) rep_d[cur_q] = rep_q[cur_q] + 1'b1;
      end else begin
        rep_d[cur_q] = REP_W'(1);
      end
      rep_hit = (rep_d[cur_q] == REP_W'(REP_LIMIT));
    end
    // A health failure overrides any word completion in the same cycle.
    if (rep_hit) begin
      state_d    = S_FAIL;
      fail_src_d = cur_q;
      cnt_d      = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (!rstn) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      cnt_q   <= '0;
      b0_q    <= 1'b0;
      word_q  <= '0;
      disc_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      b0_q    <= b0_d;
      word_q  <= word_d;
      disc_q  <= disc_d;
    end
  end

`ifdef VNC_POOL_HEALTH_EN
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: the counter array is small and must start from a known state, so it is reset like plain flops.
    if (!rstn) begin
      for (int i = 0; i < NSRC; i++) rep_q[i] <= '0;
      last_q     <= '0;
      fail_src_q <= '0;
    end else begin
      rep_q      <= rep_d;
      last_q     <= last_d;
      fail_src_q <= fail_src_d;
    end
  end

  assign fail     = (state_q == S_FAIL);
  assign fail_src = fail_src_q;
`else
  assign fail     = 1'b0;
  assign fail_src = '0;
`endif

  assign word_data   = word_q;
  assign word_valid  = (state_q == S_HOLD);
  assign busy        = (state_q == S_FIRST) || (state_q == S_SECOND) || (state_q == S_HOLD);
  assign discard_cnt = disc_q;

endmodule

// File: tb/tb_vnc_pool_ctrl.sv
// Self-checking bench for vnc_pool_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model (health checks when VNC_POOL_HEALTH_EN is defined).
module tb_vnc_pool_ctrl;
  localparam int NSRC      = 4;
  localparam int WORD_W    = 8;
  localparam int REP_LIMIT = 7;
  localparam int CNT_W     = 6;
  localparam int DISC_MAX  = (1 << CNT_W) - 1;

  localparam int PH_IDLE   = 0;
  localparam int PH_FIRST  = 1;
  localparam int PH_SECOND = 2;
  localparam int PH_HOLD   = 3;
  localparam int PH_FAIL   = 4;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              enable = 1'b0;
  logic              word_ready = 1'b0;
  logic [NSRC-1:0]   src_bits = '0;
  logic [NSRC-1:0]   src_mask = '0;
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              busy;
  logic [CNT_W-1:0]  discard_cnt;
  logic              fail;
  logic [1:0]        fail_src;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vnc_pool_ctrl #(
    .NSRC(NSRC), .WORD_W(WORD_W), .REP_LIMIT(REP_LIMIT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .src_bits(src_bits), .src_mask(src_mask),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready), .busy(busy),
    .discard_cnt(discard_cnt), .fail(fail), .fail_src(fail_src)
  );

  // Reference model state: phase of the pair walk, accepted bits as a queue.
  int m_phase, m_cur, m_b0, m_disc, m_fail_src;
  int m_bits[$];
  int m_run[NSRC];
  int m_last[NSRC];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int next_src(input logic [NSRC-1:0] mask, input int from, input bit incl);
    for (int k = 0; k < NSRC; k++) begin
      int idx;
      idx = (from + k + (incl ? 0 : 1)) % NSRC;
      if (mask[idx]) return idx;
    end
    return 0;
  endfunction

  function automatic logic [63:0] model_word();
    logic [63:0] w;
    w = '0;
    foreach (m_bits[i]) w = w | (64'(m_bits[i]) << i);
    return w;
  endfunction

  task automatic model_reset();
    m_phase = PH_IDLE; m_cur = 0; m_b0 = 0; m_disc = 0; m_fail_src = 0;
    m_bits.delete();
    for (int i = 0; i < NSRC; i++) begin m_run[i] = 0; m_last[i] = 0; end
  endtask

  task automatic model_step(input logic en, input logic [NSRC-1:0] mask,
                            input logic [NSRC-1:0] bits, input logic rdy);
    int ph, s;
    bit go;
`ifdef VNC_POOL_HEALTH_EN
    bit hit;
    int hit_idx;
    hit = 0; hit_idx = 0;
`endif
    ph = m_phase; s = 0;
    go = en && (mask != '0);
    if (ph == PH_FIRST || ph == PH_SECOND) begin
      s = int'(bits[m_cur]);
`ifdef VNC_POOL_HEALTH_EN
      if (m_run[m_cur] > 0 && m_last[m_cur] == s)
        m_run[m_cur] = (m_run[m_cur] < REP_LIMIT) ? m_run[m_cur] + 1 : REP_LIMIT;
      else
        m_run[m_cur] = 1;
      m_last[m_cur] = s;
      hit = (m_run[m_cur] == REP_LIMIT);
      hit_idx = m_cur;
`endif
    end
    case (ph)
      PH_IDLE: begin
        m_bits.delete();
        if (go) begin m_cur = next_src(mask, 0, 1); m_phase = PH_FIRST; end
      end
      PH_FIRST: begin m_b0 = s; m_phase = PH_SECOND; end
      PH_SECOND: begin
        if (m_b0 != s) m_bits.push_back(m_b0);
        else if (m_disc < DISC_MAX) m_disc++;
        m_cur = next_src(mask, m_cur, 0);
        if (m_bits.size() == WORD_W) m_phase = PH_HOLD;
        else if (!go) begin m_phase = PH_IDLE; m_bits.delete(); end
        else m_phase = PH_FIRST;
      end
      PH_HOLD: begin
        if (rdy) begin
          m_bits.delete();
          if (go) begin m_cur = next_src(mask, m_cur, 1); m_phase = PH_FIRST; end
          else m_phase = PH_IDLE;
        end
      end
      default: ;
    endcase
`ifdef VNC_POOL_HEALTH_EN
    if (hit) begin m_phase = PH_FAIL; m_fail_src = hit_idx; m_bits.delete(); end
`endif
  endtask

  task automatic compare_all();
    check("word_valid", word_valid, 64'(m_phase == PH_HOLD));
    check("busy", busy, 64'(m_phase >= PH_FIRST && m_phase <= PH_HOLD));
    check("discard_cnt", discard_cnt, 64'(m_disc));
    check("fail", fail, 64'(m_phase == PH_FAIL));
    check("fail_src", fail_src, 64'(m_fail_src));
    if (m_phase == PH_HOLD) check("word_data", word_data, model_word());
  endtask

  // Called on a negedge: drive, step the model, compare after the edge, return on the next negedge.
  task automatic cycle(input logic en, input logic [NSRC-1:0] mask,
                       input logic [NSRC-1:0] bits, input logic rdy);
    enable = en; src_mask = mask; src_bits = bits; word_ready = rdy;
    model_step(en, mask, bits, rdy);
    @(posedge clk); #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_word_data"}, word_data, 0);
    check({tag, "_word_valid"}, word_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_discard"}, discard_cnt, 0);
    check({tag, "_fail"}, fail, 0);
    check({tag, "_fail_src"}, fail_src, 0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rstn = 1'b1;
  endtask

  logic [1:0]      pat [8];
  logic [NSRC-1:0] b;
  logic [NSRC-1:0] rmask;
  int n, p, disc_before, fail_hold;

  initial begin
    pat = '{2'b10, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01};
    @(negedge clk);
    do_reset();

    // Single-source word 10,01,10,10,01,01,10,01 -> 8'b0100_1101
    n = 0; p = 0;
    while (m_phase != PH_HOLD && n < 60) begin
      b = '0;
      if (m_phase == PH_SECOND) begin b[0] = pat[p % 8][0]; p++; end
      else b[0] = pat[p % 8][1];
      cycle(1'b1, 4'b0001, b, 1'b0);
      n++;
    end
    check("word_latency", 64'(n), 17);
    check("word_valid_dir", word_valid, 1);
    check("word_data_dir", word_data, 8'h4D);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 4'b0001, 4'($urandom_range(0, 15)), 1'b0);
      check("word_stable", word_data, 8'h4D);
    end
    cycle(1'b0, 4'b0001, '0, 1'b1);
    check("valid_drop", word_valid, 0);
    cycle(1'b0, 4'b0001, '0, 1'b1);
    check("ready_unvalid", word_valid, 0);

    // Round robin over mask 1011: src0 yields 1, src1 yields 0, src3 yields 1
    do_reset();
    n = 0;
    while (m_phase != PH_HOLD && n < 60) begin
      cycle(1'b1, 4'b1011, (m_phase == PH_SECOND) ? 4'b0110 : 4'b1001, 1'b0);
      n++;
    end
    check("rr_word", word_data, 8'h6D);
    cycle(1'b1, 4'b1011, '0, 1'b1);
    cycle(1'b1, 4'b1011, 4'b1000, 1'b0);
    disc_before = m_disc;
    check("rr_on_src3", 64'(m_phase == PH_SECOND && m_cur == 3), 1);
    cycle(1'b1, 4'b0001, 4'b0001, 1'b0);
    check("mask_flip_disc", discard_cnt, 64'(disc_before));
    for (int i = 0; i < 6; i++) cycle(1'b1, 4'b0001, 4'(i % 2), 1'b0);

    // Discards on a constant source, then saturation
    do_reset();
    for (int i = 0; i < 21; i++) cycle(1'b1, 4'b0001, 4'b1111, 1'b0);
`ifndef VNC_POOL_HEALTH_EN
    check("discard_10", discard_cnt, 10);
    check("discard_no_bits", word_valid, 0);
`endif
    for (int i = 0; i < 120; i++) cycle(1'b1, 4'b0001, 4'b1111, 1'b0);
`ifndef VNC_POOL_HEALTH_EN
    check("discard_sat", discard_cnt, 64'(DISC_MAX));
`endif

    // Enable dropped after 3 accepted bits; restart begins at bit 0
    do_reset();
    n = 0;
    while (!(m_bits.size() == 3 && m_phase == PH_FIRST) && n < 60) begin
      cycle(1'b1, 4'b0001, (m_phase == PH_SECOND) ? 4'b0000 : 4'b0001, 1'b0);
      n++;
    end
    while (m_phase != PH_IDLE && n < 60) begin
      cycle(1'b0, 4'b0001, (m_phase == PH_SECOND) ? 4'b0000 : 4'b0001, 1'b0);
      n++;
    end
    check("drop_bound", 64'(n < 60), 1);
    check("drop_idle_busy", busy, 0);
    n = 0; p = 0;
    while (m_phase != PH_HOLD && n < 60) begin
      b = '0;
      if (m_phase == PH_SECOND) begin b[0] = (p == 7) ? 1'b0 : 1'b1; p++; end
      else b[0] = (p == 7) ? 1'b1 : 1'b0;
      cycle(1'b1, 4'b0001, b, 1'b0);
      n++;
    end
    check("restart_word", word_data, 8'h80);

    // Asynchronous reset while a word is held
    cycle(1'b1, 4'b0001, 4'b0001, 1'b0);
    check("hold_before_rst", word_valid, 1);
    #2 rstn = 1'b0;
    #1;
    check_reset_outputs("async");
    model_reset();
    @(negedge clk);
    rstn = 1'b1;

`ifdef VNC_POOL_HEALTH_EN
    // src2 stuck at 0 with src0 toggling every cycle
    do_reset();
    n = 0;
    while (m_phase != PH_FAIL && n < 200) begin
      cycle(1'b1, 4'b0101, 4'(n % 2), 1'b0);
      n++;
    end
    check("health_fail", fail, 1);
    check("health_src", fail_src, 2);
    check("health_valid", word_valid, 0);
    check("health_busy", busy, 0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 4'b1111, 4'($urandom_range(0, 15)), 1'b1);
    check("health_sticky", fail, 1);
    do_reset();
`endif

    // Randomized traffic against the model
    do_reset();
    rmask = 4'b1111;
    fail_hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) rmask = 4'($urandom_range(0, 15));
      cycle($urandom_range(0, 39) != 0, rmask, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      if (m_phase == PH_FAIL) begin
        fail_hold++;
        if (fail_hold > 4) begin do_reset(); fail_hold = 0; end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
